instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch front end that produces the 32-bit instr word consumed by the decode controller.
//  Issues word requests to instruction memory (req/gnt request channel, rvalid response channel).
//  Buffers returned words with their PC in a small FIFO; hands them to decode over a valid/ready handshake.
//  Supports a redirect (branch/jump) that flushes buffered and in-flight instructions.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries; power of two, >= 2
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch word address (bits [1:0] always 0)
//  imem_gnt     in   1   memory accepts request this cycle (imem_req && imem_gnt)
//  imem_rvalid  in   1   response word valid; never in the same cycle as its gnt
//  imem_rdata   in   32  response instruction word
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address; bits [1:0] ignored (forced 0)
//  instr_valid  out  1   head of buffer holds a valid instruction
//  instr_ready  in   1   decode consumes head (instr_valid && instr_ready)
//  instr        out  32  head instruction; 32'h0000_0013 (NOP) when !instr_valid
//  instr_pc     out  32  PC of head instruction; 0 when !instr_valid
// BEHAVIOUR
//  - Reset (reset==0): state IDLE, fetch_pc=RESET_PC, FIFO empty; imem_req=0, instr_valid=0,
//    instr=32'h0000_0013, instr_pc=0, imem_addr=RESET_PC.
//  - FSM, one outstanding request max:
//    IDLE : imem_req=0; -> REQ next cycle (first cycle after reset release).
//    REQ  : imem_req=(count<FIFO_DEPTH); imem_addr=fetch_pc. On req&&gnt: fetch_pc+=4 (mod 2^32),
//           -> WAIT. imem_req depends only on registered state/count, never on redirect.
//    WAIT : imem_req=0. On rvalid: push {fetch_pc-4, rdata}, -> REQ.
//    DRAIN: imem_req=0. On rvalid: discard rdata, -> REQ.
//  - Redirect (highest priority, any state): FIFO flushed, fetch_pc<=redirect_pc&~3.
//    From WAIT without rvalid, or REQ with req&&gnt same cycle -> DRAIN.
//    From WAIT with rvalid same cycle: response discarded -> REQ. From IDLE/REQ (no gnt) -> REQ.
//    From DRAIN: stay DRAIN unless rvalid same cycle -> REQ.
//    A pop handshake in the redirect cycle is void; decode discards it.
//  - Request gating reserves space: a request is issued only if count<FIFO_DEPTH, so every push fits;
//    no overflow path exists. Push and pop in the same cycle: count unchanged, order preserved.
//  - FIFO outputs driven from head register/pointer (no combinational path from imem_rdata to instr);
//    min latency rvalid -> instr_valid = 1 cycle. Peak throughput 1 instr per 2 cycles (zero-wait memory).
//  - Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  - Reset asserted mid-transaction: everything returns to reset values immediately; a late rvalid
//    arriving after release (IDLE/REQ) is ignored.
// TESTING
//  1. Reset release, gnt always 1, rvalid 1 cycle after gnt, ready=1 -> addrs 0x0,0x4,0x8...;
//     instr/instr_pc match memory contents in order, instr_valid first high 3 cycles after release.
//  2. ready=0 -> after FIFO_DEPTH (2) pushes, imem_req stays 0; raise ready -> fetch resumes at 0x8,
//     no instruction lost or duplicated.
//  3. redirect=1, redirect_pc=0x0000_1003 while in WAIT -> DRAIN; in-flight word dropped, FIFO empty,
//     next imem_addr=0x0000_1000, first delivered instr_pc=0x1000.
//  4. redirect in same cycle as rvalid and as a pop -> word discarded, pop void, next fetch at redirect_pc.
//  5. fetch_pc=0xFFFF_FFFC -> next imem_addr wraps to 0x0000_0000.
//  6. Assert reset while in WAIT with 2 entries buffered -> instr_valid=0, instr=0x13, imem_req=0
//     immediately; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end.
// Issues one word request at a time to instruction memory, buffers returned
// words with their PC in a small FIFO and presents the head to decode over a
// valid/ready handshake. A redirect flushes the buffer and restarts fetch;
// a response still in flight at that point is drained and dropped.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   logic [1:0]    state, state_nxt;
   logic [31:0]   fetch_pc;
   entry_t        fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rptr, wptr;
   logic [CW-1:0] count;
   entry_t        head;

   logic fire, push, pop;

   // Request only when a slot is reserved for the answer, so a push always fits.
   assign imem_req  = (state == S_REQ) && (count < CW'(FIFO_DEPTH));
   assign imem_addr = fetch_pc;
   assign fire      = imem_req && imem_gnt;
   // A response landing in the redirect cycle belongs to the old stream.
   assign push      = (state == S_WAIT) && imem_rvalid && !redirect;
   // Decode ignores a handshake made in the redirect cycle.
   assign pop       = instr_valid && instr_ready && !redirect;

   assign head        = fifo_q[rptr];
   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? head.data : NOP;
   assign instr_pc    = instr_valid ? head.pc   : 32'h0;

   // Next-state logic; a redirect only decides whether a response is still owed.
   always_comb begin
      state_nxt = state;
      if (redirect) begin
         case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   state_nxt = fire ? S_DRAIN : S_REQ;
            S_WAIT:  state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
            default: state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
         endcase
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   state_nxt = fire ? S_WAIT : S_REQ;
            S_WAIT:  state_nxt = imem_rvalid ? S_REQ : S_WAIT;
            default: state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
         endcase
      end
   end

   // State register and fetch PC; redirect target is forced word aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (redirect)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
         else if (fire)
            fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // FIFO pointers and occupancy; redirect empties the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (redirect) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; fetch_pc already points past the word being returned.
   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wptr] <= '{pc: fetch_pc - 32'd4, data: imem_rdata};
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed phases plus a randomized phase, checked against a
// queue-based model of the fetch stream (expected addresses, buffered words).
module tb_instr_fetch;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int          D   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid, instr_ready = 1'b0;
   logic [31:0] instr, instr_pc;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   int          tests = 0, fails = 0;
   ent_t        q[$];
   logic [31:0] mpc, out_addr;
   bit          outst, discard, idle, stray;
   int          dly, dly_min, dly_max;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mpc = RPC; out_addr = RPC;
      outst = 0; discard = 0; idle = 1; dly = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   32'(imem_req), 32'h0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
      chk({tag, "_instr"}, instr, 32'h0000_0013);
      chk({tag, "_pc"},    instr_pc, 32'h0);
      chk({tag, "_addr"},  imem_addr, RPC);
   endtask

   // One clock: drive at negedge, check, then advance the model at posedge.
   task automatic cyc(input bit g, input bit rdy, input bit rd, input logic [31:0] rp);
      bit rv, exp_req, fire;
      rv = (outst && dly == 0) || stray;
      if (outst && dly > 0) dly--;
      imem_gnt = g; instr_ready = rdy; redirect = rd; redirect_pc = rp;
      imem_rvalid = rv;
      imem_rdata  = stray ? 32'hDEAD_BEEF : memfn(out_addr);
      #1;
      exp_req = 0;
      if (!reset) chk_reset_vals("in_reset");
      else begin
         exp_req = !idle && !outst && (q.size() < D);
         chk("imem_req", 32'(imem_req), 32'(exp_req));
         if (exp_req) chk("imem_addr", imem_addr, mpc);
         chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("instr", instr, q[0].data);
            chk("instr_pc", instr_pc, q[0].pc);
         end else begin
            chk("instr_nop", instr, 32'h0000_0013);
            chk("instr_pc_zero", instr_pc, 32'h0);
         end
      end
      fire = exp_req && g;
      @(posedge clk);
      if (!reset) model_reset();
      else begin
         if (rd) begin
            q.delete();
            mpc = rp & ~32'h3;
            if (rv && outst) outst = 0;
            else if (outst) discard = 1;
            if (fire) begin outst = 1; discard = 1; dly = $urandom_range(dly_max, dly_min); end
         end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (rv && outst) begin
               if (!discard) q.push_back('{out_addr, memfn(out_addr)});
               outst = 0; discard = 0;
            end
            if (fire) begin
               outst = 1; discard = 0; out_addr = mpc; mpc = mpc + 32'd4;
               dly = $urandom_range(dly_max, dly_min);
            end
         end
         idle = 0;
      end
      stray = 0;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0; imem_gnt = 0; imem_rvalid = 0; redirect = 0; instr_ready = 0;
      #1;
      chk_reset_vals("reset_now");
      model_reset();
      repeat (n) cyc(0, 0, 0, 32'h0);
   endtask

   initial begin
      int k;
      stray = 0; dly_min = 0; dly_max = 0;
      model_reset();
      #2 reset = 1'b0;
      @(negedge clk);

      // Phase 1: reset, then streaming with zero-wait memory.
      do_reset(2);
      reset = 1'b1;
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 0, 32'h0);
      chk("first_valid_early", 32'(instr_valid), 32'h0);
      cyc(1, 1, 0, 32'h0);
      chk("first_valid_lat3", 32'(instr_valid), 32'h1);
      chk("first_pc", instr_pc, RPC);
      repeat (16) cyc(1, 1, 0, 32'h0);

      // Phase 2: decode stalls, buffer fills, requests stop; then resume.
      repeat (12) cyc(1, 0, 0, 32'h0);
      chk("stall_no_req", 32'(imem_req), 32'h0);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      repeat (12) cyc(1, 1, 0, 32'h0);

      // Phase 3: redirect while waiting on memory.
      dly_min = 1; dly_max = 1;
      k = 0;
      while (!(outst && dly > 0) && k < 50) begin cyc(1, 1, 0, 32'h0); k++; end
      chk("wait_for_wait_state", 32'(k < 50), 32'h1);
      cyc(1, 1, 1, 32'h0000_1003);
      k = 0;
      while (q.size() == 0 && k < 50) begin cyc(1, 0, 0, 32'h0); k++; end
      chk("redir_first_pc", instr_pc, 32'h0000_1000);
      repeat (6) cyc(1, 1, 0, 32'h0);

      // Phase 4: redirect colliding with a response and a pop.
      k = 0;
      while (!(q.size() == 1 && outst && dly == 0) && k < 50) begin cyc(1, 0, 0, 32'h0); k++; end
      chk("wait_for_collision", 32'(k < 50), 32'h1);
      cyc(1, 1, 1, 32'h0000_2000);
      chk("collide_flushed", 32'(instr_valid), 32'h0);
      chk("collide_req", 32'(imem_req), 32'h1);
      chk("collide_addr", imem_addr, 32'h0000_2000);
      repeat (8) cyc(1, 1, 0, 32'h0);

      // Phase 5: address wrap at the top of memory.
      dly_min = 0; dly_max = 0;
      cyc(0, 0, 1, 32'hFFFF_FFFE);
      k = 0;
      while (q.size() == 0 && k < 50) begin cyc(1, 0, 0, 32'h0); k++; end
      chk("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
      k = 0;
      while (!imem_req && k < 50) begin cyc(0, 0, 0, 32'h0); k++; end
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      repeat (8) cyc(1, 1, 0, 32'h0);

      // Phase 6: randomized traffic.
      dly_min = 0; dly_max = 3;
      repeat (400) begin
         cyc($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
             $urandom_range(19, 0) == 0, $urandom());
      end

      // Phase 7: reset while a request is outstanding with data buffered.
      dly_min = 2; dly_max = 2;
      k = 0;
      while (!(outst && q.size() >= 1) && k < 50) begin cyc(1, 0, 0, 32'h0); k++; end
      chk("wait_for_busy", 32'(k < 50), 32'h1);
      do_reset(2);
      reset = 1'b1;
      stray = 1;
      cyc(1, 1, 0, 32'h0);
      chk("post_reset_addr", imem_addr, RPC);
      dly_min = 0; dly_max = 1;
      repeat (20) cyc(1, 1, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
